// File: rtl/env_follower.sv
// Envelope follower: rectifies signed audio, tracks level with attack/release steps, regenerates a hysteretic gate.
// Optional peak-hold register and ports are enabled by defining ENV_FOLLOWER_PEAK_EN.
module env_follower #(
  parameter int SAMPLE_W = 8,
  parameter int HOLD_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ce,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic [7:0]                 ai,
  input  logic [7:0]                 ri,
  input  logic [7:0]                 thr_on,
  input  logic [7:0]                 thr_off,
  input  logic [HOLD_W-1:0]          hold_len,
`ifdef ENV_FOLLOWER_PEAK_EN
  input  logic                       peak_clr,
  output logic [7:0]                 peak,
`endif
  output logic [7:0]                 envelope,
  output logic                       env_valid,
  output logic                       gate
);

  typedef enum logic [1:0] {IDLE, ON, HOLD} state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;

  logic                vld_p0;
  logic [SAMPLE_W-2:0] mag_p0;
  logic [7:0]          mag8_p0;
  logic [7:0]          env_nxt_p0;

  // Absolute value; the most negative code saturates to the largest positive magnitude.
  function automatic logic [SAMPLE_W-2:0] rectify(input logic signed [SAMPLE_W-1:0] s);
    logic signed [SAMPLE_W-1:0] neg;
    neg = -s;
    if (s == {1'b1, {(SAMPLE_W-1){1'b0}}})
      return {(SAMPLE_W-1){1'b1}};
    else if (s[SAMPLE_W-1])
      return neg[SAMPLE_W-2:0];
    else
      return s[SAMPLE_W-2:0];
  endfunction

  // Step toward mag8 without overshooting it; 9-bit sums so no wrap at either end.
  function automatic logic [7:0] track(input logic [7:0] env, input logic [7:0] mag8,
                                       input logic [7:0] up_step, input logic [7:0] dn_step);
    logic [8:0] up;
    logic [8:0] dn;
    up = {1'b0, env} + {1'b0, up_step};
    dn = {1'b0, env} - {1'b0, dn_step};
    if (mag8 > env)
      return (up > {1'b0, mag8}) ? mag8 : up[7:0];
    else if (mag8 < env)
      return (dn[8] || (dn[7:0] < mag8)) ? mag8 : dn[7:0];
    else
      return env;
  endfunction

  // Stage p0: accept, rectify and compute the next envelope
  assign vld_p0     = ce & in_valid;
  assign mag_p0     = rectify(sample);
  assign mag8_p0    = {mag_p0[SAMPLE_W-2 -: 7], 1'b0};
  assign env_nxt_p0 = track(envelope, mag8_p0, ai, ri);

  // Stage p1: registered envelope and valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      envelope  <= '0;
      env_valid <= 1'b0;
    end else begin
      env_valid <= vld_p0;
      if (vld_p0)
        envelope <= env_nxt_p0;
    end
  end

  // Gate decisions look at the envelope held before this sample's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      gate     <= 1'b0;
    end else if (vld_p0) begin
      case (state)
        IDLE: begin
          if (envelope >= thr_on) begin
            state <= ON;
            gate  <= 1'b1;
          end
        end
        ON: begin
          if (envelope < thr_off) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
        end
        HOLD: begin
          if (envelope >= thr_on) begin
            state    <= ON;
            hold_cnt <= '0;
          end else if (hold_cnt == hold_len) begin
            state <= IDLE;
            gate  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
          gate     <= 1'b0;
        end
      endcase
    end
  end

`ifdef ENV_FOLLOWER_PEAK_EN
  // Clear reloads from the envelope, taking the freshly tracked value when a sample lands together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak <= '0;
    end else if (ce) begin
      if (peak_clr)
        peak <= vld_p0 ? env_nxt_p0 : envelope;
      else if (vld_p0 && (env_nxt_p0 > peak))
        peak <= env_nxt_p0;
    end
  end
`endif

endmodule

// File: tb/tb_env_follower.sv
// Self-checking bench for env_follower: directed spec scenarios plus randomized traffic against an integer model.
module tb_env_follower;
  localparam int SAMPLE_W = 8;
  localparam int HOLD_W   = 8;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       ce = 1'b0;
  logic                       in_valid = 1'b0;
  logic signed [SAMPLE_W-1:0] sample = '0;
  logic [7:0]                 ai = '0;
  logic [7:0]                 ri = '0;
  logic [7:0]                 thr_on = 8'hff;
  logic [7:0]                 thr_off = '0;
  logic [HOLD_W-1:0]          hold_len = '0;
  logic [7:0]                 envelope;
  logic                       env_valid;
  logic                       gate;
`ifdef ENV_FOLLOWER_PEAK_EN
  logic                       peak_clr = 1'b0;
  logic [7:0]                 peak;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: level as an int, gate phase 0=idle 1=on 2=hold
  int m_env = 0;
  int m_phase = 0;
  int m_cnt = 0;
  int m_peak = 0;
  bit m_vld = 1'b0;

  env_follower #(.SAMPLE_W(SAMPLE_W), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .sample(sample),
    .ai(ai), .ri(ri), .thr_on(thr_on), .thr_off(thr_off), .hold_len(hold_len),
`ifdef ENV_FOLLOWER_PEAK_EN
    .peak_clr(peak_clr), .peak(peak),
`endif
    .envelope(envelope), .env_valid(env_valid), .gate(gate)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    int s, mag, mag8, nenv, maxmag;
    bit acc, clr;
    acc = ce && in_valid;
    clr = 1'b0;
`ifdef ENV_FOLLOWER_PEAK_EN
    clr = ce && peak_clr;
`endif
    m_vld = acc;
    nenv = m_env;
    if (acc) begin
      s = int'(sample);
      maxmag = (1 << (SAMPLE_W - 1)) - 1;
      mag = (s < 0) ? -s : s;
      if (mag > maxmag) mag = maxmag;
      mag8 = (mag >> (SAMPLE_W - 8)) * 2;
      if (mag8 > m_env)      nenv = (m_env + int'(ai) < mag8) ? m_env + int'(ai) : mag8;
      else if (mag8 < m_env) nenv = (m_env - int'(ri) > mag8) ? m_env - int'(ri) : mag8;
      case (m_phase)
        0: if (m_env >= int'(thr_on)) m_phase = 1;
        1: if (m_env < int'(thr_off)) begin m_phase = 2; m_cnt = 0; end
        default: begin
          if (m_env >= int'(thr_on)) begin m_phase = 1; m_cnt = 0; end
          else if (m_cnt == int'(hold_len)) m_phase = 0;
          else m_cnt++;
        end
      endcase
    end
    if (clr) m_peak = nenv;
    else if (acc && nenv > m_peak) m_peak = nenv;
    m_env = nenv;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic model_clear();
    m_env = 0; m_phase = 0; m_cnt = 0; m_peak = 0; m_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({envelope, env_valid, gate} !== 10'd0) begin
      errors++;
      $display("FAIL reset: env=%0d vld=%0b gate=%0b, expected all 0", envelope, env_valid, gate);
    end
`ifdef ENV_FOLLOWER_PEAK_EN
    checks++;
    if (peak !== 8'd0) begin errors++; $display("FAIL reset_peak: got %0d expected 0", peak); end
`endif
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Ramp from 0 with ai=16 toward mag8=128, in_valid held high every cycle.
  task automatic test_attack();
    int exp_env;
    thr_on = 8'd100; thr_off = 8'd50; hold_len = HOLD_W'(2);
    ai = 8'd16; ri = 8'd0; sample = SAMPLE_W'(64); ce = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_env = (16 * k < 128) ? 16 * k : 128;
      checks++;
      if ({envelope, env_valid, gate} !== {8'(m_env), m_vld, m_phase != 0}) begin
        errors++;
        $display("FAIL attack_model k=%0d: env=%0d vld=%0b gate=%0b expected env=%0d vld=%0b gate=%0b",
                 k, envelope, env_valid, gate, m_env, m_vld, m_phase != 0);
      end
      checks++;
      if ({envelope, gate} !== {8'(exp_env), k >= 8}) begin
        errors++;
        $display("FAIL attack_seq k=%0d: env=%0d gate=%0b expected env=%0d gate=%0b",
                 k, envelope, gate, exp_env, k >= 8);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (env_valid !== 1'b0 || envelope !== 8'd128) begin
      errors++;
      $display("FAIL attack_idle: vld=%0b env=%0d expected vld=0 env=128", env_valid, envelope);
    end
  endtask

  // Release from 128 with ri=32; HOLD entered on the sample that sees 32, gate drops three HOLD samples later.
  task automatic test_release();
    int exp_env;
    ri = 8'd32; sample = '0;
    for (int r = 1; r <= 8; r++) begin
      in_valid = 1'b1;
      tick();
      exp_env = (128 - 32 * r > 0) ? 128 - 32 * r : 0;
      checks++;
      if ({envelope, env_valid, gate} !== {8'(exp_env), 1'b1, r < 7}) begin
        errors++;
        $display("FAIL release r=%0d: env=%0d vld=%0b gate=%0b expected env=%0d vld=1 gate=%0b",
                 r, envelope, env_valid, gate, exp_env, r < 7);
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (env_valid !== 1'b0 || envelope !== 8'(m_env)) begin
        errors++;
        $display("FAIL release_gap r=%0d: vld=%0b env=%0d expected vld=0 env=%0d", r, env_valid, envelope, m_env);
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [SAMPLE_W-1:0] pats [4];
    logic [7:0] exps [4];
    do_reset();
    pats[0] = SAMPLE_W'(-128); exps[0] = 8'd254;
    pats[1] = SAMPLE_W'(127);  exps[1] = 8'd254;
    pats[2] = SAMPLE_W'(-127); exps[2] = 8'd254;
    pats[3] = SAMPLE_W'(1);    exps[3] = 8'd2;
    ai = 8'd255; ri = 8'd255; thr_on = 8'd255; thr_off = 8'd0; ce = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample = pats[i];
      tick();
      checks++;
      if (envelope !== exps[i] || envelope !== 8'(m_env)) begin
        errors++;
        $display("FAIL saturation i=%0d: env=%0d expected %0d (model %0d)", i, envelope, exps[i], m_env);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_ce();
    ce = 1'b0; in_valid = 1'b1; sample = SAMPLE_W'(100); ai = 8'd50;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (env_valid !== 1'b0 || envelope !== 8'd2) begin
        errors++;
        $display("FAIL ce_drop i=%0d: vld=%0b env=%0d expected vld=0 env=2", i, env_valid, envelope);
      end
    end
    ce = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_reattack();
    do_reset();
    thr_on = 8'd100; thr_off = 8'd50; hold_len = HOLD_W'(3);
    ai = 8'd16; sample = SAMPLE_W'(64); ce = 1'b1; in_valid = 1'b1;
    repeat (8) tick();
    ri = 8'd64; sample = '0;
    repeat (3) tick();
    ai = 8'd255; sample = SAMPLE_W'(64);
    repeat (2) tick();
    ri = 8'd128; sample = '0;
    for (int i = 6; i <= 12; i++) begin
      tick();
      checks++;
      if ({envelope, gate} !== {8'(m_env), m_phase != 0} || gate !== (i < 11)) begin
        errors++;
        $display("FAIL reattack s=%0d: env=%0d gate=%0b expected env=%0d gate=%0b",
                 i, envelope, gate, m_env, i < 11);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    thr_on = 8'd64; thr_off = 8'd32; ai = 8'd16; sample = SAMPLE_W'(64); ce = 1'b1; in_valid = 1'b1;
    repeat (5) tick();
    checks++;
    if (envelope !== 8'd80 || gate !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: env=%0d gate=%0b expected env=80 gate=1", envelope, gate);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({envelope, env_valid, gate} !== 10'd0) begin
      errors++;
      $display("FAIL mid_reset: env=%0d vld=%0b gate=%0b expected all 0", envelope, env_valid, gate);
    end
    model_clear();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      ce       = ($urandom_range(0, 9) < 8);
      in_valid = ($urandom_range(0, 9) < 7);
      sample   = SAMPLE_W'($urandom);
      ai       = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 80));
      ri       = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 80));
      if ($urandom_range(0, 15) == 0) begin
        thr_on  = 8'($urandom_range(40, 220));
        thr_off = 8'($urandom_range(0, 255));
        hold_len = HOLD_W'($urandom_range(0, 3));
      end
`ifdef ENV_FOLLOWER_PEAK_EN
      peak_clr = ($urandom_range(0, 19) == 0);
`endif
      tick();
      checks++;
      if ({envelope, env_valid, gate} !== {8'(m_env), m_vld, m_phase != 0}) begin
        errors++;
        $display("FAIL random i=%0d: env=%0d vld=%0b gate=%0b expected env=%0d vld=%0b gate=%0b",
                 i, envelope, env_valid, gate, m_env, m_vld, m_phase != 0);
      end
`ifdef ENV_FOLLOWER_PEAK_EN
      checks++;
      if (peak !== 8'(m_peak)) begin
        errors++;
        $display("FAIL random_peak i=%0d: got %0d expected %0d", i, peak, m_peak);
      end
`endif
    end
`ifdef ENV_FOLLOWER_PEAK_EN
    peak_clr = 1'b0;
`endif
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_attack();
    test_release();
    test_saturation();
    test_ce();
    test_reattack();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
